// File: rtl/seg7_pkg.sv
// Shared constants for the 6-digit HH.MM.SS seven-segment scanner:
// glyph table, digit positions and the BCD-to-segment encoder.
package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [2:0] DIG_SEC_ONES = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS = 3'd1;
   localparam logic [2:0] DIG_MIN_ONES = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS = 3'd3;
   localparam logic [2:0] DIG_HR_ONES  = 3'd4;
   localparam logic [2:0] DIG_HR_TENS  = 3'd5;

   // Segment order is g..a (bit 6 = g, bit 0 = a).
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] bcd, input logic ovf);
      if (ovf || bcd > 4'd9) return SEG_DASH;
      return SEG_DIGIT[bcd];
   endfunction

endpackage

// File: rtl/seg7_time_scanner_if.sv
// Time-value inputs and multiplexed display outputs of the seven-segment scanner.
interface seg7_time_scanner_if;
   logic [7:0] hour;
   logic [7:0] minute;
   logic [7:0] second;
   logic [2:0] blink_mask;
   logic [7:0] seg;
   logic [5:0] an;

   modport master (output hour, minute, second, blink_mask, input seg, an);
   modport slave  (input hour, minute, second, blink_mask, output seg, an);
endinterface

// File: rtl/bin2bcd_99.sv
// Splits a binary value into two BCD digits; ovf flags values that do not fit in 0..99.
module bin2bcd_99 (
   input  logic [7:0] value,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       ovf
);

   assign ovf  = (value >= 8'd100);
   assign tens = ovf ? 4'd0 : 4'(value / 8'd10);
   assign ones = ovf ? 4'd0 : 4'(value % 8'd10);

endmodule

// File: rtl/seg7_time_scanner.sv
// Drives a 6-digit multiplexed HH.MM.SS display from a per-frame snapshot of the
// time counters, with per-field blinking and an anti-ghosting dead cycle per digit.
module seg7_time_scanner
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_DIV  = 500000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_time_scanner_if.slave  disp
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

   logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
   logic [2:0]            digit_q, digit_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_ph_q, blink_ph_d;
   logic [7:0]            snap_hour_q, snap_min_q, snap_sec_q;
   logic [2:0]            snap_mask_q;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic       hr_ovf, min_ovf, sec_ovf;
   logic       scan_wrap, frame_wrap;

   bin2bcd_99 u_bcd_hr  (.value(snap_hour_q), .tens(hr_tens),  .ones(hr_ones),  .ovf(hr_ovf));
   bin2bcd_99 u_bcd_min (.value(snap_min_q),  .tens(min_tens), .ones(min_ones), .ovf(min_ovf));
   bin2bcd_99 u_bcd_sec (.value(snap_sec_q),  .tens(sec_tens), .ones(sec_ones), .ovf(sec_ovf));

   logic [3:0]            cur_bcd;
   logic                  cur_ovf, cur_blink;
   logic [7:0]            seg_raw;
   logic [NUM_DIGITS-1:0] an_raw;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      scan_wrap   = (scan_cnt_q == SCAN_LAST);
      frame_wrap  = scan_wrap && (digit_q == DIG_HR_TENS);
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      digit_d     = digit_q;
      if (scan_wrap) digit_d = frame_wrap ? DIG_SEC_ONES : digit_q + 3'd1;
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_ph_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_ph_q : blink_ph_q;

      cur_bcd   = 4'd0;
      cur_ovf   = 1'b0;
      cur_blink = 1'b0;
      case (digit_q)
         DIG_SEC_ONES: begin cur_bcd = sec_ones; cur_ovf = sec_ovf; cur_blink = snap_mask_q[0]; end
         DIG_SEC_TENS: begin cur_bcd = sec_tens; cur_ovf = sec_ovf; cur_blink = snap_mask_q[0]; end
         DIG_MIN_ONES: begin cur_bcd = min_ones; cur_ovf = min_ovf; cur_blink = snap_mask_q[1]; end
         DIG_MIN_TENS: begin cur_bcd = min_tens; cur_ovf = min_ovf; cur_blink = snap_mask_q[1]; end
         DIG_HR_ONES:  begin cur_bcd = hr_ones;  cur_ovf = hr_ovf;  cur_blink = snap_mask_q[2]; end
         DIG_HR_TENS:  begin cur_bcd = hr_tens;  cur_ovf = hr_ovf;  cur_blink = snap_mask_q[2]; end
         default:      ;
      endcase

      // dp marks the HH.MM and MM.SS separators; blanking removes it along with the glyph.
      seg_raw = {(digit_q == DIG_MIN_ONES) || (digit_q == DIG_HR_ONES), seg_encode(cur_bcd, cur_ovf)};
      if (blink_ph_q && cur_blink) seg_raw = {1'b0, SEG_BLANK};
      an_raw  = scan_wrap ? '0 : NUM_DIGITS'(1) << digit_q;

      seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
      an_d  = ACTIVE_LOW ? ~an_raw  : an_raw;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         digit_q     <= DIG_SEC_ONES;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         snap_hour_q <= '0;
         snap_min_q  <= '0;
         snap_sec_q  <= '0;
         snap_mask_q <= '0;
         seg_q       <= SEG_OFF;
         an_q        <= AN_OFF;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         digit_q     <= digit_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         if (frame_wrap) begin
            snap_hour_q <= disp.hour;
            snap_min_q  <= disp.minute;
            snap_sec_q  <= disp.second;
            snap_mask_q <= disp.blink_mask;
         end
      end
   end

   assign disp.seg = seg_q;
   assign disp.an  = an_q;

endmodule
